// File: rtl/jtcps1_vram_arb_if.sv
// SDRAM read port shared by the CPS1 VRAM clients.
// The master side is the arbiter; the slave side is the SDRAM controller.
interface jtcps1_vram_arb_if;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_din;

    modport master (
        output sdram_addr,
        output sdram_req,
        input  sdram_ack,
        input  sdram_rdy,
        input  sdram_din
    );

    modport slave (
        input  sdram_addr,
        input  sdram_req,
        output sdram_ack,
        output sdram_rdy,
        output sdram_din
    );
endinterface

// File: rtl/jtcps1_vram_arb.sv
// Fixed-priority arbiter of the scroll, object and palette VRAM readers onto one SDRAM read port.
// Each client owns a one-word result register tagged with the address it was fetched for.
module jtcps1_vram_arb #(
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic [16:0]       vram1_addr,
    input  logic [16:0]       vram_obj_addr,
    input  logic [16:0]       vpal_addr,
    input  logic              vram1_cs,
    input  logic              vram_obj_cs,
    input  logic              vpal_cs,

    output logic [15:0]       vram1_data,
    output logic [15:0]       vram_obj_data,
    output logic [15:0]       vpal_data,
    output logic              vram1_ok,
    output logic              vram_obj_ok,
    output logic              vpal_ok,

    jtcps1_vram_arb_if.master sdram
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitData
    } state_t;

    // Client index 0 = vram1 (highest priority), 1 = vram_obj, 2 = vpal.
    logic [2:0][16:0] addr;
    logic [2:0]       cs;
    logic [2:0]       hit;
    logic [2:0]       miss;
    logic [2:0]       ok;

    logic [2:0][16:0] tag_q;
    logic [2:0][15:0] data_q;
    logic [2:0]       valid_q;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [1:0]       pick;
    logic             discard_q;
    logic             req_q;
    logic [21:0]      addr_q;
    logic             done;

    assign addr = {vpal_addr, vram_obj_addr, vram1_addr};
    assign cs   = {vpal_cs, vram_obj_cs, vram1_cs};

    always_comb begin
        hit  = '0;
        miss = '0;
        for (int i = 0; i < 3; i++) begin
            hit[i]  = valid_q[i] && (addr[i] == tag_q[i]);
            miss[i] = cs[i] && !hit[i];
        end
        ok = cs & hit;
    end

    always_comb begin
        pick = 2'd2;
        if (miss[0]) begin
            pick = 2'd0;
        end else if (miss[1]) begin
            pick = 2'd1;
        end
    end

    // A read finishes either on rdy in WAIT_DATA or on ack+rdy together in WAIT_ACK.
    always_comb begin
        done = 1'b0;
        case (state_q)
            StWaitAck:  done = sdram.sdram_ack && sdram.sdram_rdy;
            StWaitData: done = sdram.sdram_rdy;
            default:    done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= 2'd0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            valid_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= '0;
            end
            case (state_q)
                StIdle: begin
                    if (|miss) begin
                        grant_q       <= pick;
                        tag_q[pick]   <= addr[pick];
                        valid_q[pick] <= 1'b0;
                        addr_q        <= OFFSET + {5'b0, addr[pick]};
                        req_q         <= 1'b1;
                        discard_q     <= 1'b0;
                        state_q       <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (flush) begin
                        discard_q <= 1'b1;
                    end
                    if (sdram.sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= sdram.sdram_rdy ? StIdle : StWaitData;
                    end
                end
                StWaitData: begin
                    if (flush) begin
                        discard_q <= 1'b1;
                    end
                    if (sdram.sdram_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
            // Data is always kept; a flush seen during the read leaves it invalid.
            if (done) begin
                data_q[grant_q]  <= sdram.sdram_din;
                valid_q[grant_q] <= !(discard_q || flush);
            end
        end
    end

    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_addr = addr_q;

    assign vram1_data    = data_q[0];
    assign vram_obj_data = data_q[1];
    assign vpal_data     = data_q[2];
    assign vram1_ok      = ok[0];
    assign vram_obj_ok   = ok[1];
    assign vpal_ok       = ok[2];

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Directed bench for jtcps1_vram_arb: a per-cycle vector table plus a few hand-written sequences.
// A second instance with a large offset checks 22-bit address wrap.
module tb_jtcps1_vram_arb;

    localparam logic [16:0] A1 = 17'h00020;
    localparam logic [16:0] AO = 17'h00010;
    localparam logic [16:0] AP = 17'h00100;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [2:0]  cs;
        logic [16:0] a1, ao, ap;
        logic        ack, rdy;
        logic [15:0] din;
        logic        req;
        logic [21:0] saddr;
        logic [2:0]  ok;
        int          dsel;
        logic [15:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [16:0] a1, ao, ap;
    logic        c1, co, cp;
    logic        ack, rdy;
    logic [15:0] din;

    logic [15:0] d1, dob, dp, wd1, wdo, wdp;
    logic        k1, ko, kp, wk1, wko, wkp;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    jtcps1_vram_arb_if bus ();
    jtcps1_vram_arb_if bus_w ();

    assign bus.sdram_ack   = ack;
    assign bus.sdram_rdy   = rdy;
    assign bus.sdram_din   = din;
    assign bus_w.sdram_ack = ack;
    assign bus_w.sdram_rdy = rdy;
    assign bus_w.sdram_din = din;

    always #5 clk = ~clk;

    jtcps1_vram_arb #(.OFFSET(22'h10000)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .vram1_addr(a1), .vram_obj_addr(ao), .vpal_addr(ap),
        .vram1_cs(c1), .vram_obj_cs(co), .vpal_cs(cp),
        .vram1_data(d1), .vram_obj_data(dob), .vpal_data(dp),
        .vram1_ok(k1), .vram_obj_ok(ko), .vpal_ok(kp),
        .sdram(bus.master)
    );

    jtcps1_vram_arb #(.OFFSET(22'h3F0000)) u_wrap (
        .clk(clk), .rst(rst), .flush(flush),
        .vram1_addr(a1), .vram_obj_addr(ao), .vpal_addr(ap),
        .vram1_cs(c1), .vram_obj_cs(co), .vpal_cs(cp),
        .vram1_data(wd1), .vram_obj_data(wdo), .vpal_data(wdp),
        .vram1_ok(wk1), .vram_obj_ok(wko), .vpal_ok(wkp),
        .sdram(bus_w.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic [2:0] c,
                       input logic [16:0] x1, input logic [16:0] xo, input logic [16:0] xp,
                       input logic k, input logic y, input logic [15:0] dn,
                       input logic q, input logic [21:0] sa, input logic [2:0] okv,
                       input int ds, input logic [15:0] dd);
        vec_t v;
        v.rst = r; v.flush = f; v.cs = c; v.a1 = x1; v.ao = xo; v.ap = xp;
        v.ack = k; v.rdy = y; v.din = dn;
        v.req = q; v.saddr = sa; v.ok = okv; v.dsel = ds; v.data = dd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic f, input logic [2:0] c,
                         input logic k, input logic y, input logic [15:0] dn);
        rst = r; flush = f; c1 = c[0]; co = c[1]; cp = c[2];
        ack = k; rdy = y; din = dn;
    endtask

    function automatic logic [15:0] data_of(input int ds);
        case (ds)
            0:       return d1;
            1:       return dob;
            default: return dp;
        endcase
    endfunction

    initial begin
        a1 = A1; ao = AO; ap = AP;
        drive(1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0);

        // Reset held three cycles with every client requesting.
        for (int i = 0; i < 3; i++) add(1, 0, 3'b111, A1, AO, AP, 0, 0, 0, 0, 22'h0, 3'b000, 3, 0);
        // Contention: vram1, then vram_obj (ack+rdy together), then vpal.
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10020, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10020, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 1, 16'h1111, 0, 22'h10020, 3'b001, 0, 16'h1111);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10010, 3'b001, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 1, 16'h1234, 0, 22'h10010, 3'b011, 1, 16'h1234);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10100, 3'b011, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10100, 3'b011, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10100, 3'b011, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b011, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b011, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 1, 16'hBEEF, 0, 22'h10100, 3'b111, 2, 16'hBEEF);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b111, 3, 0);
        // Stray ack/rdy in IDLE are ignored.
        add(0, 0, 3'b111, A1, AO, AP, 1, 1, 16'hDEAD, 0, 22'h10100, 3'b111, 2, 16'hBEEF);
        // Flush in IDLE drops every ok.
        add(0, 1, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10020, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10020, 3'b000, 3, 0);
        // Flush during WAIT_DATA: data stored, not valid, fetch reissued.
        add(0, 1, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10020, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 1, 16'h2222, 0, 22'h10020, 3'b000, 0, 16'h2222);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10020, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10020, 3'b000, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 0, 1, 16'h3333, 0, 22'h10020, 3'b001, 0, 16'h3333);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10010, 3'b001, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 1, 16'h4444, 0, 22'h10010, 3'b011, 1, 16'h4444);
        add(0, 0, 3'b111, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10100, 3'b011, 3, 0);
        add(0, 0, 3'b111, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10100, 3'b011, 3, 0);
        // Flush together with rdy discards the result.
        add(0, 1, 3'b111, A1, AO, AP, 0, 1, 16'h5555, 0, 22'h10100, 3'b000, 2, 16'h5555);
        add(0, 0, 3'b000, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b000, 3, 0);
        // vram_obj address changes during WAIT_DATA.
        add(0, 0, 3'b010, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10010, 3'b000, 3, 0);
        add(0, 0, 3'b010, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10010, 3'b000, 3, 0);
        add(0, 0, 3'b010, A1, 17'h11, AP, 0, 0, 16'h0000, 0, 22'h10010, 3'b000, 3, 0);
        add(0, 0, 3'b010, A1, 17'h11, AP, 0, 1, 16'h6666, 0, 22'h10010, 3'b000, 1, 16'h6666);
        add(0, 0, 3'b010, A1, 17'h11, AP, 0, 0, 16'h0000, 1, 22'h10011, 3'b000, 3, 0);
        add(0, 0, 3'b010, A1, 17'h11, AP, 1, 1, 16'h7777, 0, 22'h10011, 3'b010, 1, 16'h7777);
        // vpal drops cs mid-transaction; result still stored and hits later.
        add(0, 0, 3'b100, A1, AO, AP, 0, 0, 16'h0000, 1, 22'h10100, 3'b000, 3, 0);
        add(0, 0, 3'b000, A1, AO, AP, 1, 0, 16'h0000, 0, 22'h10100, 3'b000, 3, 0);
        add(0, 0, 3'b000, A1, AO, AP, 0, 1, 16'h8888, 0, 22'h10100, 3'b000, 2, 16'h8888);
        add(0, 0, 3'b100, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b100, 2, 16'h8888);
        add(0, 0, 3'b100, A1, AO, AP, 0, 0, 16'h0000, 0, 22'h10100, 3'b100, 3, 0);
        // Reset abandons an in-flight read; the late rdy is ignored.
        add(0, 0, 3'b001, 17'h21, AO, AP, 0, 0, 16'h0000, 1, 22'h10021, 3'b000, 3, 0);
        add(0, 0, 3'b001, 17'h21, AO, AP, 1, 0, 16'h0000, 0, 22'h10021, 3'b000, 3, 0);
        add(1, 0, 3'b001, 17'h21, AO, AP, 0, 0, 16'h0000, 0, 22'h00000, 3'b000, 0, 16'h0);
        add(0, 0, 3'b000, 17'h21, AO, AP, 0, 1, 16'h9999, 0, 22'h00000, 3'b000, 0, 16'h0);
        add(0, 0, 3'b001, 17'h21, AO, AP, 0, 0, 16'h0000, 1, 22'h10021, 3'b000, 3, 0);
        add(0, 0, 3'b001, 17'h21, AO, AP, 1, 1, 16'hAAAA, 0, 22'h10021, 3'b001, 0, 16'hAAAA);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].cs, vecs[i].ack, vecs[i].rdy, vecs[i].din);
            a1 = vecs[i].a1; ao = vecs[i].ao; ap = vecs[i].ap;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_req", i), {31'b0, bus.sdram_req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d_addr", i), {10'b0, bus.sdram_addr}, {10'b0, vecs[i].saddr});
            check($sformatf("v%0d_ok", i), {29'b0, kp, ko, k1}, {29'b0, vecs[i].ok});
            if (vecs[i].dsel < 3) begin
                check($sformatf("v%0d_data", i), {16'b0, data_of(vecs[i].dsel)},
                      {16'b0, vecs[i].data});
            end
        end

        // Address wrap: 22'h3F0000 + 17'h1FFFF wraps to 22'h00FFFF.
        ap = 17'h1FFFF;
        drive(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        check("wrap_req", {31'b0, bus_w.sdram_req}, 32'd1);
        check("wrap_addr", {10'b0, bus_w.sdram_addr}, 32'h0000FFFF);
        check("nowrap_addr", {10'b0, bus.sdram_addr}, 32'h0002FFFF);
        drive(1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 16'hC0DE);
        @(posedge clk);
        #1;
        check("wrap_ok", {31'b0, kp}, 32'd1);
        check("wrap_data", {16'b0, dp}, 32'h0000C0DE);
        check("wrap_inst_data", {16'b0, wdp}, 32'h0000C0DE);

        // Hit is combinational: ok in the same cycle cs rises, no request.
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        check("hit_off_ok", {31'b0, kp}, 32'd0);
        cp = 1'b1;
        #1;
        check("hit_same_cycle_ok", {31'b0, kp}, 32'd1);
        check("hit_same_cycle_data", {16'b0, dp}, 32'h0000C0DE);
        @(posedge clk);
        #1;
        check("hit_no_req", {31'b0, bus.sdram_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
